// File: rtl/alu4bit_arbiter.sv
// Round-robin front end sharing one registered alu4bit between two requesters.
// Accepts an op, waits out the ALU latency, and returns the result with the requester id.
module alu4bit_arbiter #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [2:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [2:0]       req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_data,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [3:0]       alu_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q;
    logic [2:0]       cnt_q;
    logic [3:0]       alu_a_q, alu_b_q;
    logic [2:0]       alu_sel_q;
    logic             rsp_id_q;
    logic [3:0]       rsp_data_q;
    logic [CNT_W-1:0] op_count_q;

    logic gnt_any;
    logic gnt_id;
    logic accept;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = ~req0_valid;
        end
        accept = (state_q == StIdle) && gnt_any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = StWait;
            StWait: if (cnt_q == 3'd0) state_d = StResp;
            StResp: if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Ready is masked during reset so nothing appears accepted while rst_n is low.
    always_comb begin
        busy       = (state_q != StIdle);
        rsp_valid  = (state_q == StResp);
        req0_ready = rst_n && accept && !gnt_id;
        req1_ready = rst_n && accept && gnt_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            cnt_q        <= 3'd0;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            alu_sel_q    <= 3'd0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= 4'd0;
            op_count_q   <= '0;
        end else begin
            if (accept) begin
                alu_a_q      <= gnt_id ? req1_a : req0_a;
                alu_b_q      <= gnt_id ? req1_b : req0_b;
                alu_sel_q    <= gnt_id ? req1_sel : req0_sel;
                rsp_id_q     <= gnt_id;
                last_grant_q <= gnt_id;
                cnt_q        <= 3'(ALU_LAT);
            end
            if (state_q == StWait) begin
                if (cnt_q != 3'd0) begin
                    cnt_q <= cnt_q - 3'd1;
                end else begin
                    rsp_data_q <= alu_result;
                end
            end
            if (state_q == StResp && rsp_ready) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_alu4bit_arbiter.sv
// Bench for alu4bit_arbiter: a registered ALU stand-in, a transaction-level model checked
// every cycle, and directed scenarios with hand-computed results.
module tb_alu4bit_arbiter;

    localparam int unsigned ALU_LAT = 1;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CNT_MOD = 1 << CNT_W;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             req0_valid = 1'b0;
    logic [3:0]       req0_a     = 4'd0;
    logic [3:0]       req0_b     = 4'd0;
    logic [2:0]       req0_sel   = 3'd0;
    logic             req1_valid = 1'b0;
    logic [3:0]       req1_a     = 4'd0;
    logic [3:0]       req1_b     = 4'd0;
    logic [2:0]       req1_sel   = 3'd0;
    logic             rsp_ready  = 1'b1;
    logic             req0_ready, req1_ready;
    logic             rsp_valid, rsp_id;
    logic [3:0]       rsp_data, alu_a, alu_b, alu_result;
    logic [2:0]       alu_sel;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    alu4bit_arbiter #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] sel);
        case (sel)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a ^ b;
            3'd5:    return a << 1;
            3'd6:    return a >> 1;
            default: return a;
        endcase
    endfunction

    // Registered ALU stand-in with ALU_LAT pipeline stages.
    logic [3:0] alu_pipe [ALU_LAT];
    always_ff @(posedge clk) begin
        alu_pipe[0] <= alu_fn(alu_a, alu_b, alu_sel);
        for (int i = 1; i < int'(ALU_LAT); i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[ALU_LAT-1];

    // Transaction-level model: one op in flight, response after a fixed number of edges.
    bit          m_inflight, m_rsp, m_last, m_id;
    int          m_wait, m_g, m_gc;
    logic [3:0]  m_data, m_pend, m_a, m_b;
    logic [2:0]  m_sel;
    int unsigned m_count;

    function automatic int model_grant();
        if (!rst_n || m_inflight) return -1;
        if (req0_valid && req1_valid) return m_last ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inflight = 0; m_rsp = 0; m_last = 1; m_id = 0; m_wait = 0;
            m_data = 0; m_pend = 0; m_a = 0; m_b = 0; m_sel = 0; m_count = 0;
        end else begin
            m_g = model_grant();
            if (m_g >= 0) begin
                m_id       = (m_g == 1);
                m_a        = m_id ? req1_a : req0_a;
                m_b        = m_id ? req1_b : req0_b;
                m_sel      = m_id ? req1_sel : req0_sel;
                m_pend     = alu_fn(m_a, m_b, m_sel);
                m_last     = m_id;
                m_inflight = 1;
                m_wait     = int'(ALU_LAT) + 1;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_rsp  = 1;
                    m_data = m_pend;
                end
            end else if (m_rsp && rsp_ready) begin
                m_count    = (m_count + 1) % CNT_MOD;
                m_rsp      = 0;
                m_inflight = 0;
            end
        end
    end

    always @(negedge clk) begin
        m_gc = model_grant();
        check("cmp_busy", 32'(busy), 32'(m_inflight));
        check("cmp_req0_ready", 32'(req0_ready), 32'(m_gc == 0));
        check("cmp_req1_ready", 32'(req1_ready), 32'(m_gc == 1));
        check("cmp_rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        check("cmp_rsp_id", 32'(rsp_id), 32'(m_id));
        check("cmp_rsp_data", 32'(rsp_data), 32'(m_data));
        check("cmp_alu_a", 32'(alu_a), 32'(m_a));
        check("cmp_alu_b", 32'(alu_b), 32'(m_b));
        check("cmp_alu_sel", 32'(alu_sel), 32'(m_sel));
        check("cmp_op_count", 32'(op_count), 32'(m_count));
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic [3:0] a,
                           input logic [3:0] b, input logic [2:0] sel);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
        end
    endtask

    task automatic wait_ready(input int id);
        logic r;
        int n;
        n = 0;
        #1;
        r = (id == 0) ? req0_ready : req1_ready;
        while (!r && n < 50) begin
            tick();
            n++;
            r = (id == 0) ? req0_ready : req1_ready;
        end
        check("ready_wait", 32'(r), 32'd1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        check("rsp_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] sel);
        int n;
        set_req(id, 1'b1, a, b, sel);
        wait_ready(id);
        tick();
        set_req(id, 1'b0, a, b, sel);
        wait_rsp(n);
        tick();
    endtask

    logic [3:0] sweep_exp [8] = '{4'b0101, 4'b0111, 4'b1100, 4'b0010,
                                 4'b0010, 4'b1110, 4'b0011, 4'b0111};
    int  n;
    bit  seen;

    initial begin
        // Both requesters valid across reset release: 0 wins, then strict alternation.
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 4'b0111, 4'b0101, 3'b000);
        set_req(1, 1'b1, 4'b0111, 4'b0101, 3'b011);
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_req0_ready", 32'(req0_ready), 32'd1);
        check("rel_req1_ready", 32'(req1_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_rsp(n);
            check("cont_id", 32'(rsp_id), 32'(k % 2));
            check("cont_data", 32'(rsp_data), (k % 2 == 1) ? 32'b0010 : 32'b0101);
            tick();
        end
        set_req(0, 1'b0, 4'd0, 4'd0, 3'd0);
        set_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
        check("cont_count", 32'(op_count), 32'd4);

        // Single op with latency measured from the ready cycle.
        do_reset();
        set_req(0, 1'b1, 4'b0111, 4'b0101, 3'b010);
        wait_ready(0);
        tick();
        set_req(0, 1'b0, 4'b0111, 4'b0101, 3'b010);
        check("single_ready_drop", 32'(req0_ready), 32'd0);
        check("single_alu_a", 32'(alu_a), 32'b0111);
        check("single_alu_b", 32'(alu_b), 32'b0101);
        check("single_alu_sel", 32'(alu_sel), 32'b010);
        wait_rsp(n);
        check("single_latency", 32'(n + 1), 32'(ALU_LAT + 2));
        check("single_data", 32'(rsp_data), 32'b1100);
        check("single_id", 32'(rsp_id), 32'd0);
        tick();
        check("single_count", 32'(op_count), 32'd1);
        check("single_idle", 32'(busy), 32'd0);

        // Backpressure: response held, req1 stalled until the handshake.
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'b0111, 4'b0101, 3'b001);
        wait_ready(0);
        tick();
        set_req(0, 1'b0, 4'd0, 4'd0, 3'd0);
        set_req(1, 1'b1, 4'b0111, 4'b0101, 3'b011);
        wait_rsp(n);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'b0111);
            check("bp_req1_stall", 32'(req1_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_req1_still_stall", 32'(req1_ready), 32'd0);
        tick();
        check("bp_req1_accept", 32'(req1_ready), 32'd1);
        tick();
        set_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
        wait_rsp(n);
        check("bp_second_id", 32'(rsp_id), 32'd1);
        check("bp_second_data", 32'(rsp_data), 32'b0010);
        tick();

        // Sweep every op on req1 with valid held throughout.
        do_reset();
        set_req(1, 1'b1, 4'b0111, 4'b0101, 3'd0);
        for (int s = 0; s < 8; s++) begin
            wait_ready(1);
            tick();
            if (s < 7) req1_sel = 3'(s + 1);
            else req1_valid = 1'b0;
            wait_rsp(n);
            check("sweep_data", 32'(rsp_data), 32'(sweep_exp[s]));
            check("sweep_id", 32'(rsp_id), 32'd1);
            tick();
        end
        check("sweep_count", 32'(op_count), 32'd8);

        // Reset during WAIT discards the op and clears the counter at once.
        set_req(0, 1'b1, 4'b0011, 4'b0100, 3'b010);
        wait_ready(0);
        tick();
        set_req(0, 1'b0, 4'd0, 4'd0, 3'd0);
        check("mid_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_count", 32'(op_count), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_no_rsp", 32'(seen), 32'd0);
        set_req(0, 1'b1, 4'b0001, 4'b0001, 3'b010);
        set_req(1, 1'b1, 4'b0111, 4'b0001, 3'b010);
        #1;
        check("mid_grant0", 32'(req0_ready), 32'd1);
        check("mid_no_grant1", 32'(req1_ready), 32'd0);
        tick();
        set_req(0, 1'b0, 4'd0, 4'd0, 3'd0);
        set_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
        wait_rsp(n);
        check("mid_rsp_id", 32'(rsp_id), 32'd0);
        check("mid_rsp_data", 32'(rsp_data), 32'b0010);
        tick();

        // Counter wraps after 2^CNT_W handshakes.
        do_reset();
        for (int i = 0; i < int'(CNT_MOD); i++) begin
            run_op(i % 2, 4'(i), 4'(i >> 4), 3'(i));
            if (i == int'(CNT_MOD) - 2) check("wrap_max", 32'(op_count), 32'(CNT_MOD - 1));
        end
        check("wrap_zero", 32'(op_count), 32'd0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
